// File: rtl/keypad_hex_entry_pkg.sv
// Shared definitions for the hex keypad entry block: FSM state codes,
// frame classes and the frame classification helper.
package keypad_hex_entry_pkg;

  localparam int unsigned KEY_W = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_SINGLE = 2'd1,
    FC_MULTI  = 2'd2
  } frame_class_t;

  typedef struct packed {
    frame_class_t     cls;
    logic [KEY_W-1:0] code;
  } frame_info_t;

  // hits[row*4+col] set where that intersection read low during the frame
  function automatic frame_info_t classify_frame(input logic [15:0] hits);
    frame_info_t info;
    info.cls  = FC_NONE;
    info.code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (hits[i]) begin
        if (info.cls == FC_NONE) begin
          info.cls  = FC_SINGLE;
          info.code = KEY_W'(i);
        end else begin
          info.cls = FC_MULTI;
        end
      end
    end
    return info;
  endfunction

endpackage

// File: rtl/keypad_hex_entry_col_scanner.sv
// Column scanner: scan divider, active-low column rotation, row synchronizer
// and per-frame accumulation of pressed intersections.
module keypad_col_scanner
  import keypad_hex_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic             frame_end,
  output frame_class_t     frame_cls,
  output logic [KEY_W-1:0] frame_code
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [3:0]       row_s1;
  logic [3:0]       row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [1:0]       col_nx;
  logic [15:0]      mask;
  logic [15:0]      col_hits;
  logic [15:0]      frame_mask;
  logic             tick;
  frame_info_t      info;

  assign tick   = (div == DIV_W'(SCAN_DIV - 1));
  assign col_nx = col + 2'd1;

  always_comb begin
    col_hits = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col_hits[{r[1:0], col}] = ~row_s2[r];
    end
  end

  // The last column is folded in combinationally so the class is ready on the frame-end tick
  assign frame_mask = mask | col_hits;
  assign info       = classify_frame(frame_mask);
  assign frame_end  = tick && (col == 2'd3);
  assign frame_cls  = info.cls;
  assign frame_code = info.code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
      div    <= '0;
      col    <= '0;
      mask   <= '0;
      col_n  <= 4'b1110;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
      if (tick) begin
        div   <= '0;
        col   <= col_nx;
        col_n <= ~(4'b0001 << col_nx);
        mask  <= (col == 2'd3) ? '0 : frame_mask;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad entry: debounce FSM, accept pulse and 32-bit digit shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_hex_entry
  import keypad_hex_entry_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_n,
  input  logic             clear,
  output logic [3:0]       col_n,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_down,
  output logic [31:0]      value
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("keypad_hex_entry: illegal parameter value");
  end

  logic             frame_end;
  frame_class_t     frame_cls;
  logic [KEY_W-1:0] frame_code;
  logic             single_cand;

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [KEY_W-1:0] cand;
  logic [KEY_W-1:0] cand_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_FRAMES);
  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_n;
  logic [RPT_W-1:0] rpt_inc;
  assign rpt_inc = rpt + RPT_W'(1);
`endif

  keypad_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .frame_end  (frame_end),
    .frame_cls  (frame_cls),
    .frame_code (frame_code)
  );

  assign cnt_inc     = cnt + CNT_W'(1);
  assign single_cand = (frame_cls == FC_SINGLE) && (frame_code == cand);

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_n   = rpt;
`endif
    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (frame_cls == FC_SINGLE) begin
            cand_n = frame_code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_n = ST_HELD;
              accept  = 1'b1;
            end else begin
              state_n = ST_DEBOUNCE;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (single_cand) begin
            if (cnt_inc == CNT_MAX) begin
              state_n = ST_HELD;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_HELD: begin
          if (frame_cls == FC_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              state_n = ST_RELEASE;
              cnt_n   = CNT_W'(1);
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (single_cand) begin
            if (rpt_inc == RPT_MAX) begin
              accept = 1'b1;
              rpt_n  = '0;
            end else begin
              rpt_n = rpt_inc;
            end
          end else begin
            rpt_n = '0;
          end
`endif
        end
        default: begin
          if (frame_cls == FC_NONE) begin
            if (cnt_inc == CNT_MAX) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_HELD;
            cnt_n   = '0;
          end
        end
      endcase
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    // Every entry into HELD starts a fresh repeat interval
    if (state_n == ST_HELD && state != ST_HELD) begin
      rpt_n = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      value     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= accept;
      key_down  <= (state_n == ST_HELD) || (state_n == ST_RELEASE);
      if (accept) begin
        key_code <= cand_n;
      end
      if (clear) begin
        value <= accept ? {{(32 - KEY_W){1'b0}}, cand_n} : '0;
      end else if (accept) begin
        value <= {value[31-KEY_W:0], cand_n};
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt       <= rpt_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a frame-level keypad/debounce model checked every cycle,
// plus directed scenarios with literal expectations. Honours KEYPAD_AUTOREPEAT_EN.
module tb_keypad_hex_entry;

  localparam int unsigned D  = 4;
  localparam int unsigned DF = 2;
  localparam int unsigned RF = 3;
  localparam int unsigned FR = 4 * D;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] keys  = '0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] value;

  int tests_run    = 0;
  int tests_failed = 0;
  int dut_pulses   = 0;

  keypad_hex_entry #(
    .SCAN_DIV        (D),
    .DEBOUNCE_FRAMES (DF),
    .REPEAT_FRAMES   (RF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .clear     (clear),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a pressed key joins it to the driven column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: phase 0 idle, 1 debouncing, 2 held, 3 releasing
  int          n;
  int          mst, mcnt, mrpt;
  logic [3:0]  mcand;
  logic [31:0] mval;
  logic [15:0] frame_keys;
  logic        ev, edown;
  logic [3:0]  ecode, ecol;
  logic        m_rst, m_clr;
  logic [15:0] m_keys;

  task automatic frame_step(output logic acc);
    int         nk;
    logic [3:0] code;
    acc  = 1'b0;
    nk   = $countones(frame_keys);
    code = '0;
    for (int i = 0; i < 16; i++) if (frame_keys[i]) code = i[3:0];
    case (mst)
      0: if (nk == 1) begin
           mcand = code;
           if (DF == 1) begin mst = 2; acc = 1'b1; mrpt = 0; end
           else begin mst = 1; mcnt = 1; end
         end
      1: if (nk == 1 && code == mcand) begin
           mcnt++;
           if (mcnt == DF) begin mst = 2; acc = 1'b1; mrpt = 0; end
         end else mst = 0;
      2: if (nk == 0) begin
           if (DF == 1) mst = 0;
           else begin mst = 3; mcnt = 1; end
         end
`ifdef KEYPAD_AUTOREPEAT_EN
         else if (nk == 1 && code == mcand) begin
           mrpt++;
           if (mrpt == RF) begin acc = 1'b1; mrpt = 0; end
         end else mrpt = 0;
`endif
      default: if (nk == 0) begin
           mcnt++;
           if (mcnt == DF) mst = 0;
         end else begin mst = 2; mrpt = 0; end
    endcase
  endtask

  task automatic model_step();
    logic acc;
    logic [3:0] one;
    if (!m_rst) begin
      n = 0; mst = 0; mcnt = 0; mrpt = 0; mcand = '0; mval = '0;
      frame_keys = '0; ev = 1'b0; ecode = '0;
    end else begin
      acc = 1'b0;
      n++;
      if (n % FR == 1) frame_keys = m_keys;
      if (n % FR == 0) frame_step(acc);
      if (m_clr) mval = acc ? {28'h0, mcand} : 32'h0;
      else if (acc) mval = {mval[27:0], mcand};
      ev = acc;
      if (acc) ecode = mcand;
    end
    edown = (mst == 2) || (mst == 3);
    one   = 4'b0001 << ((n / D) % 4);
    ecol  = ~one;
  endtask

  always @(posedge clk) begin
    m_rst  = rst_n;
    m_clr  = clear;
    m_keys = keys;
    #1;
    model_step();
    if (key_valid === 1'b1) dut_pulses++;
    chk("col_n", col_n, ecol);
    chk("key_valid", key_valid, ev);
    chk("key_code", key_code, ecode);
    chk("key_down", key_down, edown);
    chk("value", value, mval);
  end

  // Entered and left on a falling edge; keys held for one whole frame
  task automatic run_frame(input logic [15:0] k, input int clr_at);
    keys = k;
    for (int i = 0; i < FR; i++) begin
      clear = (i == clr_at);
      @(negedge clk);
    end
    clear = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst_n = 1'b0;
    keys  = k;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input int k);
    logic [15:0] b;
    b = 16'h1 << k;
    run_frame(b, -1);
    run_frame(b, -1);
    run_frame('0, -1);
    run_frame('0, -1);
  endtask

  initial begin
    int p0;
    logic [15:0] k;
    int kind, hold, clr_at;

    @(negedge clk);
    do_reset('0);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_value", value, 32'h0);
    chk("rst_key_down", key_down, 1'b0);

    repeat (4) @(negedge clk);
    chk("col_step1", col_n, 4'b1101);
    repeat (4) @(negedge clk);
    chk("col_step2", col_n, 4'b1011);
    repeat (8) @(negedge clk);

    p0 = dut_pulses;
    repeat (3) run_frame(16'h1 << 6, -1);
    chk("press6_pulses", dut_pulses - p0, 1);
    chk("press6_code", key_code, 4'd6);
    chk("press6_value", value, 32'h0000_0006);
    run_frame('0, -1);
    chk("release_down_1", key_down, 1'b1);
    run_frame('0, -1);
    chk("release_down_2", key_down, 1'b0);

    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? (16'h1 << 3) : 16'h0, -1);
    chk("bounce_pulses", dut_pulses - p0, 0);
    chk("bounce_down", key_down, 1'b0);

    run_frame('0, 5);
    for (int d = 1; d <= 9; d++) begin
      press(d);
      if (d == 8) chk("entry_8", value, 32'h1234_5678);
    end
    chk("entry_9", value, 32'h2345_6789);
    run_frame(16'h1 << 10, -1);
    run_frame(16'h1 << 10, FR - 1);
    chk("clear_accept", value, 32'h0000_000A);
    run_frame('0, -1);
    run_frame('0, -1);

    p0 = dut_pulses;
    repeat (3) run_frame(16'h0021, -1);
    chk("ghost_pulses", dut_pulses - p0, 0);
    chk("ghost_down", key_down, 1'b0);
    repeat (2) run_frame(16'h0020, -1);
    chk("held5_pulses", dut_pulses - p0, 1);
    repeat (2) run_frame(16'h0021, -1);
    chk("held5_multi_pulses", dut_pulses - p0, 1);
    chk("held5_multi_down", key_down, 1'b1);
    run_frame('0, -1);
    run_frame('0, -1);

    run_frame(16'h1 << 12, -1);
    repeat (7) @(negedge clk);
    do_reset(16'h1 << 12);
    p0 = dut_pulses;
    repeat (3) run_frame(16'h1 << 12, -1);
    chk("reset_held_pulses", dut_pulses - p0, 1);
    chk("reset_held_value", value, 32'h0000_000C);
    run_frame('0, -1);
    run_frame('0, -1);

`ifdef KEYPAD_AUTOREPEAT_EN
    run_frame('0, 2);
    p0 = dut_pulses;
    repeat (12) run_frame(16'h8000, -1);
    chk("repeat_pulses", dut_pulses - p0, 4);
    chk("repeat_value", value, 32'h0000_FFFF);
    run_frame('0, -1);
    run_frame('0, -1);
`endif

    for (int it = 0; it < 250; it++) begin
      kind   = $urandom_range(0, 19);
      clr_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FR - 1)) : -1;
      if (kind < 7) begin
        run_frame('0, clr_at);
      end else if (kind < 16) begin
        k    = 16'h1 << $urandom_range(0, 15);
        hold = $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) run_frame(k, (h == 0) ? clr_at : -1);
      end else if (kind < 19) begin
        k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        run_frame(k, clr_at);
      end else begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        do_reset(keys);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
